// File: rtl/off_chip_pkg.sv
// Shared types and constants for the off-chip lane serializer slice.
package off_chip_pkg;

  localparam int unsigned DATA_W     = 64;
  localparam int unsigned LANE_W     = 16;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned CREDIT_MAX = 8;
  localparam int unsigned LANE_BEATS = DATA_W / LANE_W;
  localparam int unsigned CREDIT_W   = 4;

  // Serializer FSM: one idle state plus one state per lane beat.
  typedef enum logic [2:0] {
    StIdle,
    StBeat0,
    StBeat1,
    StBeat2,
    StBeat3
  } lane_state_e;

  // Even parity: XOR of all bits, so data plus parity has an even number of ones.
  function automatic logic even_parity(input logic [LANE_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/off_chip_lane_serializer_if.sv
// Upstream word handshake, lane beat outputs and credit return, bundled for the serializer.
interface off_chip_lane_serializer_if;
  import off_chip_pkg::*;

  logic [DATA_W-1:0]   in_data;
  logic                in_valid;
  logic                in_ready;
  logic [LANE_W-1:0]   lane_data;
  logic                lane_valid;
  logic                lane_sof;
  logic                lane_parity;
  logic                credit_ret;
  logic [CREDIT_W-1:0] credits;
  logic                credit_err;

  // Driver side: upstream stage plus far-end credit return.
  modport master (
    output in_data,
    output in_valid,
    output credit_ret,
    input  in_ready,
    input  lane_data,
    input  lane_valid,
    input  lane_sof,
    input  lane_parity,
    input  credits,
    input  credit_err
  );

  // Serializer side.
  modport slave (
    input  in_data,
    input  in_valid,
    input  credit_ret,
    output in_ready,
    output lane_data,
    output lane_valid,
    output lane_sof,
    output lane_parity,
    output credits,
    output credit_err
  );

endinterface

// File: rtl/off_chip_sync_fifo.sv
// Small synchronous FIFO with registered count. Storage is not reset; only pointers and count.
module off_chip_sync_fifo
  import off_chip_pkg::*;
#(
  parameter int unsigned Depth = DEPTH,
  parameter int unsigned Width = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  // Full/empty come only from the registered count; a full FIFO refuses a push even on a pop.
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/off_chip_lane_serializer.sv
// Buffers 64-bit words and serializes each onto a 16-bit lane as four credit-gated beats.
module off_chip_lane_serializer
  import off_chip_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  off_chip_lane_serializer_if.slave   bus
);

  localparam logic [CREDIT_W-1:0] CreditMax = CREDIT_W'(CREDIT_MAX);

  lane_state_e         state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [CREDIT_W-1:0] credits_q, credits_d;
  logic                credit_err_q, credit_err_d;
  logic [LANE_W-1:0]   lane_data_q, lane_data_d;
  logic                lane_valid_q, lane_valid_d;
  logic                lane_sof_q, lane_sof_d;
  logic                lane_parity_q, lane_parity_d;

  logic [DATA_W-1:0]   fifo_rdata;
  logic                fifo_full, fifo_empty;
  logic                push, pop, word_slot;

  assign push      = bus.in_valid && !fifo_full;
  // A new word may start only when the lane is free or finishing its last beat.
  assign word_slot = (state_q == StIdle) || (state_q == StBeat3);
  assign pop       = word_slot && !fifo_empty && (credits_q != '0);

  off_chip_sync_fifo #(
    .Depth (DEPTH),
    .Width (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (bus.in_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // FSM next state, shift register and registered lane outputs derived from the next state.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    unique case (state_q)
      StIdle:  state_d = pop ? StBeat0 : StIdle;
      StBeat0: state_d = StBeat1;
      StBeat1: state_d = StBeat2;
      StBeat2: state_d = StBeat3;
      StBeat3: state_d = pop ? StBeat0 : StIdle;
      default: state_d = StIdle;
    endcase

    // Low half goes out first, so the shift register moves right one lane per beat.
    if (pop) begin
      shreg_d = fifo_rdata;
    end else if (state_q == StBeat0 || state_q == StBeat1 || state_q == StBeat2) begin
      shreg_d = shreg_q >> LANE_W;
    end

    lane_valid_d  = (state_d != StIdle);
    lane_sof_d    = (state_d == StBeat0);
    lane_data_d   = lane_valid_d ? shreg_d[LANE_W-1:0] : '0;
    lane_parity_d = even_parity(lane_data_d);
  end

  // Credit counter: pop consumes, credit_ret replenishes, saturation with sticky error.
  always_comb begin
    credits_d    = credits_q;
    credit_err_d = credit_err_q;
    unique case ({pop, bus.credit_ret})
      2'b10: credits_d = credits_q - CREDIT_W'(1);
      2'b01: begin
        if (credits_q == CreditMax) begin
          credit_err_d = 1'b1;
        end else begin
          credits_d = credits_q + CREDIT_W'(1);
        end
      end
      default: credits_d = credits_q;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      shreg_q       <= '0;
      credits_q     <= CreditMax;
      credit_err_q  <= 1'b0;
      lane_data_q   <= '0;
      lane_valid_q  <= 1'b0;
      lane_sof_q    <= 1'b0;
      lane_parity_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      credits_q     <= credits_d;
      credit_err_q  <= credit_err_d;
      lane_data_q   <= lane_data_d;
      lane_valid_q  <= lane_valid_d;
      lane_sof_q    <= lane_sof_d;
      lane_parity_q <= lane_parity_d;
    end
  end

  assign bus.in_ready    = !fifo_full;
  assign bus.lane_data   = lane_data_q;
  assign bus.lane_valid  = lane_valid_q;
  assign bus.lane_sof    = lane_sof_q;
  assign bus.lane_parity = lane_parity_q;
  assign bus.credits     = credits_q;
  assign bus.credit_err  = credit_err_q;

endmodule

// File: tb/tb_off_chip_lane_serializer.sv
// Bench for off_chip_lane_serializer: directed scenarios plus random traffic against a queue model.
module tb_off_chip_lane_serializer;
  import off_chip_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  off_chip_lane_serializer_if bus ();

  off_chip_lane_serializer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model: queued words, word on the lane, beat index (-1 = idle), credits.
  logic [63:0] m_q[$];
  logic [63:0] m_cur = '0;
  int          m_beat = -1;
  int          m_cred = 8;
  bit          m_err = 1'b0;
  bit          m_pushed = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance the model by one clock edge using the inputs presented at that edge.
  task automatic model_step();
    bit ready, pop, push, ret;
    if (rst) begin
      m_q.delete();
      m_beat   = -1;
      m_cred   = CREDIT_MAX;
      m_err    = 1'b0;
      m_pushed = 1'b0;
      return;
    end
    ready = (m_q.size() != DEPTH);
    pop   = (m_beat < 0 || m_beat == 3) && (m_q.size() != 0) && (m_cred != 0);
    push  = bus.in_valid && ready;
    ret   = bus.credit_ret;
    if (pop) begin
      m_cur  = m_q.pop_front();
      m_beat = 0;
    end else if (m_beat >= 0 && m_beat < 3) begin
      m_beat++;
    end else begin
      m_beat = -1;
    end
    if (push) m_q.push_back(bus.in_data);
    m_pushed = push;
    if (pop && !ret) m_cred--;
    else if (ret && !pop) begin
      if (m_cred == CREDIT_MAX) m_err = 1'b1;
      else m_cred++;
    end
  endtask

  task automatic compare_all();
    logic [63:0] sh;
    logic [15:0] exp_data;
    bit          exp_valid;
    exp_valid = (m_beat >= 0);
    sh        = exp_valid ? (m_cur >> (16 * m_beat)) : 64'd0;
    exp_data  = sh[15:0];
    check_eq("in_ready", bus.in_ready, m_q.size() != DEPTH);
    check_eq("lane_valid", bus.lane_valid, exp_valid);
    check_eq("lane_sof", bus.lane_sof, m_beat == 0);
    check_eq("lane_data", bus.lane_data, exp_data);
    check_eq("lane_parity", bus.lane_parity, ^exp_data);
    check_eq("credits", bus.credits, m_cred);
    check_eq("credit_err", bus.credit_err, m_err);
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid   = 1'b0;
    bus.credit_ret = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  // Hold valid until accepted, then drop it for one cycle.
  task automatic push_word(input logic [63:0] w);
    bit ok = 1'b0;
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      cycle();
      if (m_pushed) begin
        ok = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
    check_eq("push_accept", ok, 1'b1);
    cycle();
  endtask

  initial begin
    logic [63:0] w, w9;
    int first, vcount, pct;

    bus.in_data    = '0;
    bus.in_valid   = 1'b0;
    bus.credit_ret = 1'b0;

    // Reset state and single-word latency/beat order.
    do_reset();
    check_eq("rst_ready", bus.in_ready, 1'b1);
    check_eq("rst_valid", bus.lane_valid, 1'b0);
    check_eq("rst_data", bus.lane_data, 16'h0);
    check_eq("rst_credits", bus.credits, 4'd8);
    check_eq("rst_err", bus.credit_err, 1'b0);
    w = 64'h8877_6655_4433_2211;
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    cycle();
    check_eq("acc_edge_valid", bus.lane_valid, 1'b0);
    bus.in_valid = 1'b0;
    cycle();
    check_eq("beat0_data", bus.lane_data, 16'h2211);
    check_eq("beat0_sof", bus.lane_sof, 1'b1);
    check_eq("beat0_par", bus.lane_parity, 1'b0);
    check_eq("beat0_cred", bus.credits, 4'd7);
    cycle();
    check_eq("beat1_data", bus.lane_data, 16'h4433);
    check_eq("beat1_sof", bus.lane_sof, 1'b0);
    cycle();
    check_eq("beat2_data", bus.lane_data, 16'h6655);
    cycle();
    check_eq("beat3_data", bus.lane_data, 16'h8877);
    cycle();
    check_eq("post_valid", bus.lane_valid, 1'b0);

    // Pop and credit return on the same edge leave credits unchanged.
    bus.in_data  = {$urandom, $urandom};
    bus.in_valid = 1'b1;
    cycle();
    bus.in_valid   = 1'b0;
    bus.credit_ret = 1'b1;
    cycle();
    bus.credit_ret = 1'b0;
    check_eq("popret_sof", bus.lane_sof, 1'b1);
    check_eq("popret_cred", bus.credits, 4'd7);
    repeat (4) cycle();

    // Nine words, eight credits: the ninth waits for one returned credit.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      w = {$urandom, $urandom};
      if (k == 8) w9 = w;
      push_word(w);
    end
    repeat (60) cycle();
    check_eq("starved_cred", bus.credits, 4'd0);
    check_eq("starved_valid", bus.lane_valid, 1'b0);
    bus.credit_ret = 1'b1;
    cycle();
    bus.credit_ret = 1'b0;
    check_eq("ret_edge_valid", bus.lane_valid, 1'b0);
    check_eq("ret_edge_cred", bus.credits, 4'd1);
    cycle();
    check_eq("w9_sof", bus.lane_sof, 1'b1);
    check_eq("w9_data", bus.lane_data, w9[15:0]);
    check_eq("w9_cred", bus.credits, 4'd0);
    repeat (4) cycle();

    // Fill the FIFO with no credits; a fifth word is refused until space frees.
    for (int k = 0; k < 4; k++) push_word({$urandom, $urandom});
    check_eq("full_ready", bus.in_ready, 1'b0);
    bus.in_data  = {$urandom, $urandom};
    bus.in_valid = 1'b1;
    for (int t = 0; t < 3; t++) begin
      cycle();
      check_eq("full_refuse", bus.in_ready, 1'b0);
    end
    first  = -1;
    vcount = 0;
    for (int t = 0; t < 30; t++) begin
      bus.credit_ret = (t < 4);
      cycle();
      if (m_pushed) bus.in_valid = 1'b0;
      if (first < 0 && bus.lane_sof) first = t;
      if (first >= 0 && t < first + 16 && bus.lane_valid) vcount++;
    end
    bus.in_valid = 1'b0;
    check_eq("b2b_beats", vcount, 16);

    // Saturate credits, then one more return sets the sticky error.
    bus.credit_ret = 1'b1;
    for (int t = 0; t < 60; t++) begin
      if (bus.credits == 4'd8) break;
      cycle();
    end
    check_eq("sat_cred", bus.credits, 4'd8);
    check_eq("sat_err_before", bus.credit_err, 1'b0);
    cycle();
    bus.credit_ret = 1'b0;
    check_eq("sat_cred_after", bus.credits, 4'd8);
    check_eq("sat_err_after", bus.credit_err, 1'b1);
    repeat (5) cycle();
    check_eq("err_sticky", bus.credit_err, 1'b1);
    do_reset();
    check_eq("err_cleared", bus.credit_err, 1'b0);

    // Reset during BEAT1 discards the rest of the word.
    w = {$urandom, $urandom};
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    cycle();
    cycle();
    check_eq("midrst_beat1", bus.lane_data, w[31:16]);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_eq("midrst_valid", bus.lane_valid, 1'b0);
    check_eq("midrst_cred", bus.credits, 4'd8);
    check_eq("midrst_ready", bus.in_ready, 1'b1);
    for (int t = 0; t < 6; t++) begin
      cycle();
      check_eq("midrst_quiet", bus.lane_valid, 1'b0);
    end

    // Random traffic with alternating credit-return rates.
    for (int i = 0; i < 3000; i++) begin
      pct = ((i / 500) % 2 == 1) ? 30 : 10;
      bus.credit_ret = ($urandom_range(0, 99) < pct);
      cycle();
      if (m_pushed) begin
        bus.in_valid = 1'b0;
      end else if (!bus.in_valid && $urandom_range(0, 1) == 1) begin
        bus.in_data  = {$urandom, $urandom};
        bus.in_valid = 1'b1;
      end
    end
    bus.in_valid   = 1'b0;
    bus.credit_ret = 1'b0;
    repeat (4) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
